// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage.
package pipe_pkg;

    // Occupancy of the stage: nothing, main register only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } stage_state_t;

    localparam int unsigned PIPE_CTRL_W_DEF = 4;
    localparam int unsigned PIPE_CNT_W_DEF  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = PIPE_CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count up on inc, stick at all-ones, clear on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready handshake,
// registered in_ready and synchronous flush of in-flight control.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters;
// otherwise the counter outputs read 0 and perf_clr is ignored.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = PIPE_CTRL_W_DEF,
    parameter int unsigned DATA_W = 101,
    parameter int unsigned CNT_W  = PIPE_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  bubble_cycles
);

    stage_state_t      state_q;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              acc;
    logic              pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // Occupancy FSM; in_ready is precomputed for the next state so it leaves a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            // Kill control only; stale data is harmless behind out_valid=0.
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && !pop) begin
                        // Downstream stalled: park the new entry behind main.
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                        state_q     <= ST_FULL;
                        in_ready_q  <= 1'b0;
                    end else if (acc) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (pop) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        state_q     <= ST_ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Control is masked whenever nothing valid is presented.
    always_comb begin
        out_ctrl = '0;
        if (out_valid) begin
            out_ctrl = main_ctrl_q;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .clr  (perf_clr),
        .count(stall_cycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (~out_valid),
        .clr  (perf_clr),
        .count(bubble_cycles)
    );
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cycles    = '0;
    assign bubble_cycles   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted entries are queued at the
// clock edge, a negedge monitor compares and pops whenever the DUT presents.
module tb_pipe_stage_skid;

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned DATA_W = 101;
    localparam int unsigned CNT_W  = 32;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              perf_clr;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  bubble_cycles;

    int errors = 0;
    int checks = 0;

    ent_t              exp_q[$];
    logic [DATA_W-1:0] rx[$];

    pipe_stage_skid #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_data     (out_data),
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles)
    );

`ifdef PIPE_STAGE_PERF_EN
    // Small-counter instance held permanently stalled to reach saturation.
    logic             s_in_ready;
    logic             s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [3:0]       s_stall;
    logic [3:0]       s_bubble;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (4)
    ) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .flush        (1'b0),
        .in_valid     (1'b1),
        .in_ready     (s_in_ready),
        .in_ctrl      (4'h1),
        .in_data      ('0),
        .out_valid    (s_out_valid),
        .out_ready    (1'b0),
        .out_ctrl     (s_out_ctrl),
        .out_data     (s_out_data),
        .perf_clr     (1'b0),
        .stall_cycles (s_stall),
        .bubble_cycles(s_bubble)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard producer: record what the handshake accepts; flush/reset drop all.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back('{ctrl: in_ctrl, data: in_data});
        end
    end

    // Monitor: compare presented output with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("mon_in_ready", in_ready, exp_q.size() < 2);
            check("mon_out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                check("mon_out_ctrl", out_ctrl, exp_q[0].ctrl);
                check("mon_out_data", out_data, exp_q[0].data);
                if (out_ready) begin
                    rx.push_back(out_data);
                    void'(exp_q.pop_front());
                end
            end else if (!out_valid) begin
                check("mon_idle_ctrl", out_ctrl, '0);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] seq;
        int                n_rx;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        perf_clr  = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_bubble", bubble_cycles, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // 1. Streaming 1..8 at full rate.
        rx.delete();
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = DATA_W'(i);
            in_ctrl = CTRL_W'(i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("stream_count", rx.size(), 8);
        for (int i = 0; i < 8 && i < rx.size(); i++) begin
            check("stream_data", rx[i], i + 1);
        end

        // 2. Backpressure into FULL, then drain.
        step();
        rx.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h3;
        in_data   = 'hA;
        step();
        in_data   = 'hB;
        step();
        in_valid  = 1'b0;
        @(negedge clk);
        #1;
        check("bp_full_in_ready", in_ready, 0);
        check("bp_hold_data", out_data, 'hA);
        step();
        @(negedge clk);
        #1;
        check("bp_hold_data2", out_data, 'hA);
`ifndef PIPE_STAGE_PERF_EN
        check("noperf_stall", stall_cycles, 0);
        check("noperf_bubble", bubble_cycles, 0);
`endif
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        #1;
        check("bp_ready_after_pop", in_ready, 1);
        check("bp_second_data", out_data, 'hB);
        step();
        check("bp_rx_count", rx.size(), 2);
        if (rx.size() == 2) begin
            check("bp_rx0", rx[0], 'hA);
            check("bp_rx1", rx[1], 'hB);
        end

        // 3. Flush while FULL with a same-cycle input.
        rx.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h5;
        in_data   = 'h11;
        step();
        in_ctrl   = 4'h6;
        in_data   = 'h22;
        step();
        in_ctrl   = 4'h7;
        in_data   = 'h33;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_ctrl", out_ctrl, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        step();
        check("flush_nothing_delivered", rx.size(), 0);

        // 4. Asynchronous reset mid-cycle while holding one entry.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h9;
        in_data   = 'h44;
        step();
        in_valid  = 1'b0;
        @(negedge clk);
        #2;
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_ctrl", out_ctrl, 0);
        check("async_rst_out_data", out_data, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // 5. Counters: 3 bubbles, 5 stalls, then clear.
        step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_ctrl  = 4'h2;
        in_data  = 'h55;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("perf_stall", stall_cycles, 5);
        check("perf_bubble", bubble_cycles, 3);
        out_ready = 1'b1;
        perf_clr  = 1'b1;
        step();
        perf_clr = 1'b0;
        check("perf_clr_stall", stall_cycles, 0);
        check("perf_clr_bubble", bubble_cycles, 0);
`endif

        // 6. Random traffic with occasional flush; the monitor checks order.
        rx.delete();
        seq = '0;
        for (int i = 0; i < 400; i++) begin
            seq       = seq + 1'b1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 5);
            in_ctrl   = CTRL_W'($urandom);
            in_data   = seq;
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        n_rx = rx.size();
        check("rand_some_delivered", n_rx > 50, 1);
        check("rand_drained", exp_q.size(), 0);
        for (int i = 1; i < n_rx; i++) begin
            if (rx[i] <= rx[i-1]) begin
                check("rand_strictly_increasing", rx[i], rx[i-1] + 1'b1);
            end
        end

`ifdef PIPE_STAGE_PERF_EN
        check("perf_saturated", s_stall, 4'hF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
